mem_wb_skid_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage for the multi-lane pipeline, replacing the plain MEM/WB register.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/wb_lane_resolve.sv | 65 ++++++
 rtl/mem_wb_skid_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the multi-lane pipeline writeback path.
//   - Default datapath widths (word and register address).
//   - Named constants for the writeback source select, write enable and
//     zero values used when clearing pipeline entries.
//   - wb_lane_t: one writeback lane as it leaves the MEM stage.
//   - skid_state_t: occupancy states of the MEM->WB skid buffer.
//   - state_occ(): maps a skid state to its entry count.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PipeDataW = 32;
    localparam int PipeAddrW = 5;

    localparam logic [PipeDataW-1:0] ZeroWord     = '0;
    localparam logic [PipeAddrW-1:0] ZeroRegAddr  = '0;
    localparam logic                 LwAluSrc     = 1'b0;
    localparam logic                 LwMemSrc     = 1'b1;
    localparam logic                 WriteEnable  = 1'b1;
    localparam logic                 WriteDisable = 1'b0;

    // One writeback lane at the default pipeline widths.
    typedef struct packed {
        logic                 lwsrc;  // LwMemSrc: DM data, LwAluSrc: ALU/mov result
        logic [PipeAddrW-1:0] waddr;
        logic                 we;
        logic [PipeDataW-1:0] alu;
        logic [PipeDataW-1:0] dm;
    } wb_lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    function automatic logic [1:0] state_occ(input skid_state_t s);
        case (s)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_resolve.sv
// ---------------------------------------------------------------------------
// wb_lane_resolve
// Purely combinational resolution of one writeback bundle:
//   - selects DM read data or the ALU/mov result per lane,
//   - masks writes to r0,
//   - masks intra-bundle write-after-write so only the highest-numbered
//     lane writing a given register keeps its enable.
// Ports:
//   valid      in   bundle is valid; all enables and data are 0 otherwise
//   lwsrc      in   LANES         per-lane source select
//   waddr      in   LANES*ADDR_W  per-lane destination register
//   we         in   LANES         per-lane raw write enable
//   alu        in   LANES*DATA_W  per-lane ALU/mov result
//   dm         in   LANES*DATA_W  per-lane DM read data
//   out_we     out  LANES         per-lane resolved write enable
//   out_wdata  out  LANES*DATA_W  per-lane resolved writeback data
// ---------------------------------------------------------------------------
module wb_lane_resolve
    import pipe_pkg::*;
#(
    parameter int DATA_W = PipeDataW,
    parameter int ADDR_W = PipeAddrW,
    parameter int LANES  = 2
) (
    input  logic                      valid,
    input  logic [LANES-1:0]          lwsrc,
    input  logic [LANES*ADDR_W-1:0]   waddr,
    input  logic [LANES-1:0]          we,
    input  logic [LANES*DATA_W-1:0]   alu,
    input  logic [LANES*DATA_W-1:0]   dm,
    output logic [LANES-1:0]          out_we,
    output logic [LANES*DATA_W-1:0]   out_wdata
);

    logic [LANES-1:0] waw_kill;

    // NOTE: every variable driven here gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    always_comb begin
        waw_kill  = '0;
        out_we    = '0;
        out_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            // A later lane writing the same register shadows this one.
            for (int j = i + 1; j < LANES; j++) begin
                if ((we[j] == WriteEnable) &&
                    (waddr[j*ADDR_W +: ADDR_W] == waddr[i*ADDR_W +: ADDR_W])) begin
                    waw_kill[i] = 1'b1;
                end
            end

            out_we[i] = valid && (we[i] == WriteEnable) && !waw_kill[i] &&
                        (waddr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZeroRegAddr));

            if (!valid) begin
                out_wdata[i*DATA_W +: DATA_W] = DATA_W'(ZeroWord);
            end else if (lwsrc[i] == LwMemSrc) begin
                out_wdata[i*DATA_W +: DATA_W] = dm[i*DATA_W +: DATA_W];
            end else begin
                out_wdata[i*DATA_W +: DATA_W] = alu[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_skid_stage
// MEM->WB pipeline stage holding up to two writeback bundles (main + skid)
// behind a valid/ready handshake, with flush. The main entry drives the
// outputs; wb_lane_resolve turns it into per-lane write enables and data.
// in_ready is registered so the upstream path never sees out_ready
// combinationally.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   flush       drop every buffered and incoming bundle this cycle
//   in_valid    MEM bundle valid          in_ready   stage can accept
//   in_lwsrc    per-lane source select    in_waddr   per-lane dest register
//   in_we       per-lane write enable     in_alu     per-lane ALU/mov result
//   in_dm       per-lane DM read data
//   out_valid   WB bundle valid           out_ready  WB consumer accepts
//   out_waddr   per-lane dest register    out_we     per-lane resolved enable
//   out_wdata   per-lane resolved data    occ        entries held (0..2)
// ---------------------------------------------------------------------------
module mem_wb_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PipeDataW,
    parameter int ADDR_W = PipeAddrW,
    parameter int LANES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lwsrc,
    input  logic [LANES*ADDR_W-1:0]   in_waddr,
    input  logic [LANES-1:0]          in_we,
    input  logic [LANES*DATA_W-1:0]   in_alu,
    input  logic [LANES*DATA_W-1:0]   in_dm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ADDR_W-1:0]   out_waddr,
    output logic [LANES-1:0]          out_we,
    output logic [LANES*DATA_W-1:0]   out_wdata,
    output logic [1:0]                occ
);

    // Lane entry at this instance's widths.
    typedef struct packed {
        logic              lwsrc;
        logic [ADDR_W-1:0] waddr;
        logic              we;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] dm;
    } lane_t;

    typedef lane_t [LANES-1:0] bundle_t;

    localparam lane_t LaneClear = '{
        lwsrc: LwAluSrc,
        waddr: ADDR_W'(ZeroRegAddr),
        we:    WriteDisable,
        alu:   DATA_W'(ZeroWord),
        dm:    DATA_W'(ZeroWord)
    };
    localparam bundle_t BundleClear = {LANES{LaneClear}};

    skid_state_t state_q, state_d;
    bundle_t     main_q,  main_d;
    bundle_t     skid_q,  skid_d;
    logic        in_ready_q, in_ready_d;

    bundle_t     in_bundle;
    logic        accept;
    logic        retire;

    logic [LANES-1:0]        main_lwsrc;
    logic [LANES-1:0]        main_we;
    logic [LANES*DATA_W-1:0] main_alu;
    logic [LANES*DATA_W-1:0] main_dm;

    // ---------------- packing between buses and lane entries ----------------
    always_comb begin
        in_bundle  = BundleClear;
        main_lwsrc = '0;
        main_we    = '0;
        main_alu   = '0;
        main_dm    = '0;
        out_waddr  = '0;
        for (int i = 0; i < LANES; i++) begin
            in_bundle[i].lwsrc = in_lwsrc[i];
            in_bundle[i].waddr = in_waddr[i*ADDR_W +: ADDR_W];
            in_bundle[i].we    = in_we[i];
            in_bundle[i].alu   = in_alu[i*DATA_W +: DATA_W];
            in_bundle[i].dm    = in_dm[i*DATA_W +: DATA_W];

            main_lwsrc[i]                  = main_q[i].lwsrc;
            main_we[i]                     = main_q[i].we;
            main_alu[i*DATA_W +: DATA_W]   = main_q[i].alu;
            main_dm[i*DATA_W +: DATA_W]    = main_q[i].dm;
            out_waddr[i*ADDR_W +: ADDR_W]  = main_q[i].waddr;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign occ       = state_occ(state_q);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign retire    = out_valid && out_ready;

    // ---------------- next-state and entry movement ----------------
    // Entries are cleared whenever they become empty so the outputs read 0
    // while out_valid is low.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_bundle;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    main_d = in_bundle;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = in_bundle;
                end else if (retire) begin
                    state_d = EMPTY;
                    main_d  = BundleClear;
                end
            end
            TWO: begin
                // in_ready is low here, so only a retire can move things.
                if (retire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = BundleClear;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = BundleClear;
                skid_d  = BundleClear;
            end
        endcase

        if (flush) begin
            state_d = EMPTY;
            main_d  = BundleClear;
            skid_d  = BundleClear;
        end

        in_ready_d = (state_d != TWO);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            // NOTE: the two entries are reset, not just the state, because
            // their contents are visible on out_waddr/out_wdata.
            main_q     <= BundleClear;
            skid_q     <= BundleClear;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ---------------- per-lane writeback resolution ----------------
    wb_lane_resolve #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_resolve (
        .valid     (out_valid),
        .lwsrc     (main_lwsrc),
        .waddr     (out_waddr),
        .we        (main_we),
        .alu       (main_alu),
        .dm        (main_dm),
        .out_we    (out_we),
        .out_wdata (out_wdata)
    );

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_skid_stage
// Directed scenarios followed by randomized traffic. A queue-based model of
// the stage (at most two bundles, FIFO order, registered ready) predicts the
// outputs; a negedge process compares every cycle once reset has been seen.
// ---------------------------------------------------------------------------
module tb_mem_wb_skid_stage;

    localparam int L = 2;
    localparam int A = 5;
    localparam int D = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [L-1:0]     in_lwsrc = '0;
    logic [L*A-1:0]   in_waddr = '0;
    logic [L-1:0]     in_we = '0;
    logic [L*D-1:0]   in_alu = '0;
    logic [L*D-1:0]   in_dm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [L*A-1:0]   out_waddr;
    logic [L-1:0]     out_we;
    logic [L*D-1:0]   out_wdata;
    logic [1:0]       occ;

    mem_wb_skid_stage #(.DATA_W(D), .ADDR_W(A), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lwsrc  (in_lwsrc),
        .in_waddr  (in_waddr),
        .in_we     (in_we),
        .in_alu    (in_alu),
        .in_dm     (in_dm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_waddr (out_waddr),
        .out_we    (out_we),
        .out_wdata (out_wdata),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [L-1:0]   lwsrc;
        logic [L*A-1:0] waddr;
        logic [L-1:0]   we;
        logic [L*D-1:0] alu;
        logic [L*D-1:0] dm;
    } bundle_t;

    bundle_t q[$];
    logic    m_rdy = 1'b0;

    // Walk lanes from the highest down; the first writer of a register owns it.
    function automatic logic [L-1:0] exp_we_f(input bundle_t b);
        bit claimed [32];
        logic [L-1:0] r;
        logic [A-1:0] a;
        r = '0;
        for (int k = 0; k < 32; k++) claimed[k] = 1'b0;
        for (int i = L - 1; i >= 0; i--) begin
            a = b.waddr[i*A +: A];
            if (b.we[i]) begin
                if (!claimed[a] && a != 0) r[i] = 1'b1;
                claimed[a] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [L*D-1:0] exp_wdata_f(input bundle_t b);
        logic [L*D-1:0] r;
        for (int i = 0; i < L; i++)
            r[i*D +: D] = b.lwsrc[i] ? b.dm[i*D +: D] : b.alu[i*D +: D];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_rdy <= 1'b0;
        end else begin
            bit acc;
            bit ret;
            acc = in_valid && m_rdy;
            ret = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) q.push_back(bundle_t'{in_lwsrc, in_waddr, in_we, in_alu, in_dm});
            end
            m_rdy <= (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_occ",     {62'd0, occ},  64'(q.size()));
            check("model_ready",   {63'd0, in_ready}, {63'd0, m_rdy});
            check("model_valid",   {63'd0, out_valid}, {63'd0, q.size() != 0});
            if (q.size() != 0) begin
                check("model_we",    {62'd0, out_we},    {62'd0, exp_we_f(q[0])});
                check("model_waddr", {54'd0, out_waddr}, {54'd0, q[0].waddr});
                check("model_wdata", out_wdata,          exp_wdata_f(q[0]));
            end else begin
                check("model_we_idle",    {62'd0, out_we},    64'd0);
                check("model_waddr_idle", {54'd0, out_waddr}, 64'd0);
                check("model_wdata_idle", out_wdata,          64'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 only: write register a with ALU value d.
    task automatic offer1(input logic [A-1:0] a, input logic [D-1:0] d);
        in_valid = 1'b1;
        in_lwsrc = 2'b00;
        in_we    = 2'b01;
        in_waddr = {5'd0, a};
        in_alu   = {32'h0, d};
        in_dm    = {$urandom, $urandom};
    endtask

    initial begin
        // 1. Reset held with in_valid high.
        rst = 1'b1;
        offer1(5'd9, 32'h99);
        for (int c = 0; c < 3; c++) begin
            step();
            cmp_en = 1'b1;
            check("rst_valid", {63'd0, out_valid}, 64'd0);
            check("rst_we",    {62'd0, out_we},    64'd0);
            check("rst_occ",   {62'd0, occ},       64'd0);
            check("rst_ready", {63'd0, in_ready},  64'd0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst_release_ready", {63'd0, in_ready}, 64'd1);

        // 2. Streaming, one bundle per cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer1(5'd3, 32'h10 + 32'(k));
            step();
            check("stream_valid", {63'd0, out_valid},        64'd1);
            check("stream_data",  {32'd0, out_wdata[31:0]},  64'h10 + 64'(k));
            check("stream_occ",   {62'd0, occ},              64'd1);
            check("stream_we",    {62'd0, out_we},           64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", {62'd0, occ}, 64'd0);

        // 3. Backpressure: A, B accepted, C held off.
        out_ready = 1'b0;
        offer1(5'd4, 32'hA);
        step();
        check("bp_occA", {62'd0, occ}, 64'd1);
        offer1(5'd4, 32'hB);
        step();
        check("bp_occB",   {62'd0, occ},      64'd2);
        check("bp_readyB", {63'd0, in_ready}, 64'd0);
        offer1(5'd4, 32'hC);
        step();
        check("bp_hold_occ",  {62'd0, occ},             64'd2);
        check("bp_hold_data", {32'd0, out_wdata[31:0]}, 64'hA);
        out_ready = 1'b1;
        step();
        check("bp_B_data",  {32'd0, out_wdata[31:0]}, 64'hB);
        check("bp_B_ready", {63'd0, in_ready},        64'd1);
        step();
        check("bp_C_data", {32'd0, out_wdata[31:0]}, 64'hC);
        check("bp_C_occ",  {62'd0, occ},             64'd1);
        in_valid = 1'b0;
        step();
        check("bp_empty", {62'd0, occ}, 64'd0);

        // 4. Data mux, WAW and r0 masking.
        in_valid = 1'b1;
        in_lwsrc = 2'b01;
        in_we    = 2'b11;
        in_waddr = {5'd7, 5'd7};
        in_alu   = {32'hBEEF, 32'h1111};
        in_dm    = {32'h2222, 32'hDEAD};
        step();
        check("waw_we",     {62'd0, out_we},          64'h2);
        check("waw_wdata1", {32'd0, out_wdata[63:32]}, 64'hBEEF);
        check("dm_wdata0",  {32'd0, out_wdata[31:0]},  64'hDEAD);
        in_lwsrc = 2'b00;
        in_we    = 2'b01;
        in_waddr = {5'd6, 5'd0};
        step();
        check("r0_we", {62'd0, out_we}, 64'd0);
        in_valid = 1'b0;
        step();

        // 5. Flush with two held and one offered.
        out_ready = 1'b0;
        offer1(5'd5, 32'h51);
        step();
        offer1(5'd5, 32'h52);
        step();
        check("fl_occ2", {62'd0, occ}, 64'd2);
        offer1(5'd5, 32'h53);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_occ",   {62'd0, occ},       64'd0);
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_ready", {63'd0, in_ready},  64'd1);
        out_ready = 1'b1;
        step();
        step();
        check("fl_nothing", {63'd0, out_valid}, 64'd0);

        // 6. Reset mid-operation.
        out_ready = 1'b0;
        offer1(5'd8, 32'h81);
        step();
        offer1(5'd8, 32'h82);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_occ",   {62'd0, occ},        64'd0);
        check("mrst_valid", {63'd0, out_valid},  64'd0);
        check("mrst_ready", {63'd0, in_ready},   64'd0);
        check("mrst_waddr", {54'd0, out_waddr},  64'd0);
        check("mrst_wdata", out_wdata,           64'd0);
        step();
        check("mrst_ready_up", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        offer1(5'd2, 32'h21);
        step();
        check("mrst_restart", {32'd0, out_wdata[31:0]}, 64'h21);
        in_valid = 1'b0;
        step();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 9) < 7;
            in_lwsrc  = 2'($urandom);
            in_we     = 2'($urandom);
            in_waddr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            in_alu    = {$urandom, $urandom};
            in_dm     = {$urandom, $urandom};
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
